// File: rtl/tiny_alu_pkg.sv
// rtl/tiny_alu_pkg.sv - shared widths, opcode/state enums and the single-cycle result function for tiny_alu
package tinyalu_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [OP_W-1:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4,
    rst_op = 3'd7
  } operation_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  // no_op and the reserved opcodes still complete, with a zero result
  function automatic logic [RES_W-1:0] single_cycle_result(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [RES_W-1:0] r;
    r = '0;
    case (op)
      add_op:  r = {7'b0, {1'b0, a} + {1'b0, b}};
      and_op:  r = {8'b0, a & b};
      xor_op:  r = {8'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tiny_alu_if.sv
// rtl/tiny_alu_if.sv - operand/opcode request and done/result response bundle for tiny_alu
interface tinyalu_interface;
  import tinyalu_pkg::*;

  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [OP_W-1:0]   op;
  logic              start;
  logic              done;
  logic [RES_W-1:0]  result;

  modport master (output A, B, op, start, input done, result);
  modport slave  (input A, B, op, start, output done, result);

endinterface

// File: rtl/tiny_alu_mul.sv
// rtl/tiny_alu_mul.sv - 3-stage registered 8x8 unsigned multiplier with a valid pipeline
module tiny_alu_mul
  import tinyalu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              last_o,
  output logic              valid_o,
  output logic [RES_W-1:0]  prod_o
);

  logic [DATA_W-1:0]  a_q, b_q;
  logic [DATA_W+3:0]  pp_lo_q, pp_hi_q;
  logic [RES_W-1:0]   prod_q;
  logic               v1_q, v2_q, v3_q;

  // stage 1 captures operands, stage 2 forms nibble partial products, stage 3 sums
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      pp_lo_q <= '0;
      pp_hi_q <= '0;
      prod_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (valid_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      pp_lo_q <= {4'b0, a_q} * {8'b0, b_q[3:0]};
      pp_hi_q <= {4'b0, a_q} * {8'b0, b_q[7:4]};
      prod_q  <= {4'b0, pp_lo_q} + {pp_hi_q, 4'b0};
    end
  end

  assign last_o  = v2_q;
  assign valid_o = v3_q;
  assign prod_o  = prod_q;

endmodule

// File: rtl/tiny_alu.sv
// rtl/tiny_alu.sv - 8-bit ALU with start/done handshake: control FSM, single-cycle unit, result mux
module tiny_alu
  import tinyalu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  tinyalu_interface.slave bus
);

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             mul_go;
  logic             mul_last;
  logic             mul_valid;
  logic [RES_W-1:0] mul_prod;

  tiny_alu_mul u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (mul_go),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .last_o  (mul_last),
    .valid_o (mul_valid),
    .prod_o  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    mul_go   = 1'b0;
    // the product is already visible through the output mux; latch it to hold it
    if (mul_valid) begin
      result_d = mul_prod;
    end
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == mul_op) begin
            mul_go  = 1'b1;
            state_d = BUSY;
          end else begin
            done_d   = 1'b1;
            result_d = single_cycle_result(bus.op, bus.A, bus.B);
            state_d  = WAIT_LOW;
          end
        end
      end
      BUSY: begin
        if (mul_last) begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!bus.start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // both terms come straight from registers, so no input reaches an output combinationally
  assign bus.done   = done_q | mul_valid;
  assign bus.result = mul_valid ? mul_prod : result_q;

endmodule

// File: tb/tb_tiny_alu.sv
// tb/tb_tiny_alu.sv - self-checking bench for tiny_alu against an arithmetic reference model
module tb_tiny_alu;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  tinyalu_interface bus ();

  tiny_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_result(input int o, input int a, input int b);
    int r;
    case (o)
      1:       r = a + b;
      2:       r = a & b;
      3:       r = a ^ b;
      4:       r = a * b;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic int ref_latency(input int o);
    return (o == 4) ? 3 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // launch one op, measure edges to done, check result, drop start, check pulse width
  task automatic do_op(input string tag, input int o, input int a, input int b, input bit scramble);
    int          lat;
    logic [15:0] res;
    logic [15:0] exp_r;
    exp_r     = ref_result(o, a, b);
    bus.A     = 8'(a);
    bus.B     = 8'(b);
    bus.op    = 3'(o);
    bus.start = 1'b1;
    lat       = 0;
    res       = 16'hxxxx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        res = bus.result;
        break;
      end
      if (scramble) begin
        bus.A  = 8'($urandom);
        bus.B  = 8'($urandom);
        bus.op = 3'($urandom_range(0, 7));
      end
    end
    bus.start = 1'b0;
    check({tag, ".lat"}, 32'(lat), 32'(ref_latency(o)));
    check({tag, ".res"}, {16'b0, res}, {16'b0, exp_r});
    @(negedge clk);
    check({tag, ".pulse"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int pulses;
    int a, b, o;

    bus.A     = '0;
    bus.B     = '0;
    bus.op    = '0;
    bus.start = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.done", {31'b0, bus.done}, 32'd0);
    check("rst.result", {16'b0, bus.result}, 32'd0);
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) pulses++;
    end
    check("rst.idle_no_done", 32'(pulses), 32'd0);

    do_op("add_ff", 1, 255, 255, 1'b0);
    do_op("add_3_5", 1, 3, 5, 1'b0);
    do_op("and", 2, 8'hF0, 8'h3C, 1'b0);
    do_op("xor", 3, 8'hF0, 8'h3C, 1'b0);
    do_op("mul_3_5", 4, 3, 5, 1'b0);
    do_op("mul_ff", 4, 255, 255, 1'b0);
    do_op("mul_chgA", 4, 7, 9, 1'b1);
    do_op("rsv5", 5, 9, 9, 1'b0);

    // start held high well past done must not relaunch
    bus.A     = 8'd10;
    bus.B     = 8'd20;
    bus.op    = 3'd1;
    bus.start = 1'b1;
    pulses    = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    check("hold.pulses", 32'(pulses), 32'd1);
    check("hold.result", {16'b0, bus.result}, 32'd30);
    bus.start = 1'b0;
    @(negedge clk);
    do_op("relaunch_noop", 0, 8'hAA, 8'h55, 1'b0);

    // reset while a multiply is in flight
    bus.A     = 8'd12;
    bus.B     = 8'd13;
    bus.op    = 3'd4;
    bus.start = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort.result", {16'b0, bus.result}, 32'd0);
    reset_n   = 1'b1;
    bus.start = 1'b0;
    pulses    = (bus.done !== 1'b0) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) pulses++;
    end
    check("abort.no_done", 32'(pulses), 32'd0);
    do_op("after_abort", 1, 1, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      o = int'($urandom_range(0, 7));
      if (n % 3 == 0) o = 4;
      do_op($sformatf("rnd%0d_op%0d", n, o), o, a, b, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
